// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, fetches words over imem req/ack, presents them to decode via valid/ready.
// Redirect -> imem_req next cycle; ack -> d_valid next cycle; d_ready low holds the output and stops new fetches.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic        d_adel
);

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] next_pc;
  logic        xfer, out_free;
  logic        out_load, out_adel;
  logic [31:0] out_pc, out_instr;

  assign xfer      = d_valid && d_ready;
  assign out_free  = redirect_valid || !d_valid || d_ready;
  assign next_pc   = redirect_valid ? redirect_pc : pc_q;
  assign imem_req  = (state_q == BUSY) || (state_q == DISCARD);
  assign imem_addr = req_addr_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = redirect_valid ? redirect_pc : pc_q;
    req_addr_d = req_addr_q;
    out_load   = 1'b0;
    out_pc     = 32'd0;
    out_instr  = 32'd0;
    out_adel   = 1'b0;
    case (state_q)
      IDLE: begin
        if (out_free) begin
          if (next_pc[1:0] != 2'b00) begin
            // Misaligned target becomes an exception entry instead of a fetch.
            out_load = 1'b1;
            out_pc   = next_pc;
            out_adel = 1'b1;
            state_d  = HALT;
          end else begin
            req_addr_d = next_pc;
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        if (imem_ack) begin
          if (!redirect_valid) begin
            out_load  = 1'b1;
            out_pc    = req_addr_q;
            out_instr = imem_rdata;
            pc_d      = req_addr_q + 32'd4;
            state_d   = IDLE;
          end else if (redirect_pc[1:0] == 2'b00) begin
            // Request slot is free this cycle: reissue at the target with no idle gap.
            req_addr_d = redirect_pc;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect_valid) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) state_d = IDLE;
      end
      HALT: begin
        if (redirect_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // A load only happens when the output is free, so it safely overrides flush/consume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_valid <= 1'b0;
      d_pc    <= 32'd0;
      d_instr <= 32'd0;
      d_adel  <= 1'b0;
    end else if (out_load) begin
      d_valid <= 1'b1;
      d_pc    <= out_pc;
      d_instr <= out_instr;
      d_adel  <= out_adel;
    end else begin
      if (redirect_valid || xfer) d_valid <= 1'b0;
      if (redirect_valid)         d_adel  <= 1'b0;
    end
  end

endmodule
